// File: rtl/weight_fetch_ctrl.sv
// Weight fetch read master: splits a fetch command into fixed-size AR bursts,
// captures the R beats into a FIFO and streams words to the weight buffer.
// A burst is only requested when the FIFO can absorb a full burst, because
// the slave cannot be back-pressured on the R channel.
module weight_fetch_ctrl #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int BURST_CODE  = 3,
    parameter int BURST_BEATS = 9,
    parameter int FIFO_DEPTH  = 32,
    parameter int LEN_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [AW-1:0]    araddr,
    output logic             arvalid,
    output logic [3:0]       arburst,
    input  logic             arready,
    input  logic [DW-1:0]    rdata,
    input  logic             rvalid,
    input  logic             rlast,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [DW-1:0]    w_data,
    output logic             w_last,
    output logic             busy,
    output logic             done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0] rem_req_q, rem_req_d;
    logic [LEN_W-1:0] rem_cap_q, rem_cap_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_popped_q, last_popped_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DW:0]      mem_q [FIFO_DEPTH];
    logic [DW:0]      push_word_d;

    logic             push, pop, can_issue, head_last;
    logic [LEN_W-1:0] req_step;

    // Request/handshake decode; arvalid must follow arready in the same cycle
    // to honour the first-AR latency, so it is decoded from registered state.
    always_comb begin
        can_issue   = (state_q == ISSUE) && arready &&
                      (count_q <= CW'(FIFO_DEPTH - BURST_BEATS));
        push        = busy_q && rvalid && (rem_cap_q != '0);
        pop         = (count_q != '0) && w_ready;
        head_last   = mem_q[rd_ptr_q][DW] && (count_q != '0);
        req_step    = (rem_req_q > LEN_W'(BURST_BEATS)) ? LEN_W'(BURST_BEATS) : rem_req_q;
        push_word_d = {(rem_cap_q == LEN_W'(1)), rdata};
        cmd_ready   = (state_q == IDLE);
        arvalid     = can_issue;
        araddr      = cur_addr_q;
        arburst     = 4'(BURST_CODE);
        w_valid     = (count_q != '0);
        w_data      = mem_q[rd_ptr_q][DW-1:0];
        w_last      = head_last;
        busy        = busy_q;
        done        = done_q;
    end

    // Next-state: command FSM, capture counter and FIFO pointers.
    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        rem_req_d     = rem_req_q;
        rem_cap_d     = rem_cap_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        last_popped_d = last_popped_q;
        wr_ptr_d      = wr_ptr_q + PW'(push);
        rd_ptr_d      = rd_ptr_q + PW'(pop);
        count_d       = count_q + CW'(push) - CW'(pop);

        if (push) rem_cap_d = rem_cap_q - LEN_W'(1);
        if (pop && head_last) last_popped_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d    = cmd_addr;
                    rem_req_d     = cmd_len;
                    rem_cap_d     = cmd_len;
                    last_popped_d = 1'b0;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        busy_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (can_issue) begin
                    cur_addr_d = cur_addr_q + AW'(BURST_BEATS);
                    rem_req_d  = rem_req_q - req_step;
                    state_d    = WAIT_R;
                end
            end
            WAIT_R: begin
                // The final burst may be trimmed, so its last word can leave
                // before rlast; completion still waits for rlast so no stale
                // beat can land in the next command.
                if (rvalid && rlast) begin
                    if (rem_req_q != '0) begin
                        state_d = ISSUE;
                    end else if (last_popped_q || (pop && head_last)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cur_addr_q    <= '0;
            rem_req_q     <= '0;
            rem_cap_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            last_popped_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            rem_req_q     <= rem_req_d;
            rem_cap_q     <= rem_cap_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            last_popped_q <= last_popped_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= push_word_d;
    end

    // Credit accounting must leave room for every captured beat.
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(push && (count_q == CW'(FIFO_DEPTH))));
    end
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl with a behavioural read slave (mem[i]=i)
// that returns 9 beats per request and cannot be stalled.
module tb_weight_fetch_ctrl;
    localparam int DW = 32, AW = 32, LEN_W = 16, BB = 9;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic             cmd_valid = 1'b0, cmd_ready;
    logic [AW-1:0]    cmd_addr = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [AW-1:0]    araddr;
    logic             arvalid, arready;
    logic [3:0]       arburst;
    logic [DW-1:0]    rdata;
    logic             rvalid, rlast;
    logic             w_valid, w_ready = 1'b0, w_last;
    logic [DW-1:0]    w_data;
    logic             busy, done;

    int n_checks = 0, n_pass = 0;
    int cyc = 0;

    int unsigned ar_q[$];
    int          ar_c[$];
    int unsigned pd[$];
    bit          pl[$];
    int          done_c[$];
    int          acc_c[$];
    int          last_pop_cyc = 0, last_rlast_cyc = 0, ar_viol = 0;

    weight_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .araddr(araddr), .arvalid(arvalid),
        .arburst(arburst), .arready(arready), .rdata(rdata), .rvalid(rvalid),
        .rlast(rlast), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_last(w_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model and monitor: inputs change on the falling edge, DUT outputs
    // are sampled 1 time unit later.
    initial begin
        bit            hs = 1'b0, rst_seen = 1'b0, act = 1'b0;
        int            idx = 0;
        logic [AW-1:0] base = '0, hs_addr = '0;
        arready = 1'b1; rvalid = 1'b0; rdata = '0; rlast = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_seen) act = 1'b0;
            else if (act) begin idx++; if (idx == BB) act = 1'b0; end
            if (hs) begin act = 1'b1; idx = 0; base = hs_addr; end
            arready = !act;
            rvalid  = act;
            rdata   = act ? base + idx : '0;
            rlast   = act && (idx == BB - 1);
            #1;
            rst_seen = rst_n;
            hs       = rst_n && arvalid && arready;
            hs_addr  = araddr;
            if (rst_n) begin
                if (arvalid) begin
                    ar_q.push_back(araddr); ar_c.push_back(cyc);
                    if (!arready) ar_viol++;
                end
                if (w_valid && w_ready) begin
                    pd.push_back(w_data); pl.push_back(w_last); last_pop_cyc = cyc;
                end
                if (done) done_c.push_back(cyc);
                if (cmd_valid && cmd_ready) acc_c.push_back(cyc);
                if (rvalid && rlast) last_rlast_cyc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic clear_mon();
        ar_q.delete(); ar_c.delete(); pd.delete(); pl.delete();
        done_c.delete(); acc_c.delete();
    endtask

    // One-cycle command pulse; returns on the falling edge after acceptance.
    task automatic send_cmd(input logic [AW-1:0] a, input logic [LEN_W-1:0] l);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, output bit ok);
        for (int i = 0; i < 600; i++) begin
            if (done_c.size() >= target) break;
            @(negedge clk);
        end
        ok = (done_c.size() >= target);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; w_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; #2;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); else n_pass++;
        n_checks++; if (arvalid !== 1'b0) $display("FAIL reset_arvalid got %b exp 0", arvalid); else n_pass++;
        n_checks++; if (araddr !== '0) $display("FAIL reset_araddr got %0d exp 0", araddr); else n_pass++;
        n_checks++; if (w_valid !== 1'b0) $display("FAIL reset_w_valid got %b exp 0", w_valid); else n_pass++;
        n_checks++; if (w_last !== 1'b0) $display("FAIL reset_w_last got %b exp 0", w_last); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
        n_checks++; if (arburst !== 4'd3) $display("FAIL reset_arburst got %0d exp 3", arburst); else n_pass++;
    endtask

    task automatic test_basic();
        bit ok; int errs = 0;
        clear_mon(); w_ready = 1'b1;
        send_cmd(32'd16, 16'd20);
        wait_done(1, ok);
        n_checks++; if (!ok) $display("FAIL basic_done_timeout got %0d dones exp 1", done_c.size()); else n_pass++;
        n_checks++;
        if (ar_q.size() != 3 || ar_q[0] != 16 || ar_q[1] != 25 || ar_q[2] != 34)
            $display("FAIL basic_ar_addrs got n=%0d first=%0d exp 16,25,34", ar_q.size(), ar_q.size() ? ar_q[0] : 0);
        else n_pass++;
        n_checks++;
        if (acc_c.size() != 1 || ar_c.size() == 0 || ar_c[0] != acc_c[0] + 1)
            $display("FAIL basic_first_ar_latency got ar=%0d exp accept+1", ar_c.size() ? ar_c[0] : -1);
        else n_pass++;
        for (int i = 0; i < pd.size(); i++)
            if (pd[i] != 16 + i || pl[i] != (i == 19)) errs++;
        n_checks++;
        if (pd.size() != 20 || errs != 0)
            $display("FAIL basic_data got n=%0d errs=%0d exp n=20 errs=0", pd.size(), errs);
        else n_pass++;
        n_checks++;
        if (done_c.size() == 0 || done_c[0] != ((last_pop_cyc > last_rlast_cyc) ? last_pop_cyc : last_rlast_cyc) + 1)
            $display("FAIL basic_done_cycle got %0d exp %0d", done_c.size() ? done_c[0] : -1,
                     ((last_pop_cyc > last_rlast_cyc) ? last_pop_cyc : last_rlast_cyc) + 1);
        else n_pass++;
        @(negedge clk); #2;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after got %b exp 0", busy); else n_pass++;
    endtask

    // Consumer stalls until three bursts (27 words) sit in the FIFO; free is
    // then 5 < 9, so no fourth request may appear.
    task automatic test_credit();
        bit ok; int errs = 0;
        clear_mon(); w_ready = 1'b0;
        send_cmd(32'd16, 16'd40);
        for (int i = 0; i < 200; i++) begin
            if (ar_q.size() >= 3 && last_rlast_cyc > ar_c[2]) break;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        #2;
        n_checks++; if (ar_q.size() != 3) $display("FAIL credit_stall got %0d ARs exp 3", ar_q.size()); else n_pass++;
        n_checks++; if (pd.size() != 0 || w_valid !== 1'b1)
            $display("FAIL credit_hold got pops=%0d w_valid=%b exp 0,1", pd.size(), w_valid); else n_pass++;
        @(negedge clk); w_ready = 1'b1;
        wait_done(1, ok);
        n_checks++; if (!ok) $display("FAIL credit_done_timeout got %0d dones exp 1", done_c.size()); else n_pass++;
        n_checks++;
        if (ar_q.size() != 5 || ar_q[3] != 43 || ar_q[4] != 52)
            $display("FAIL credit_ar_addrs got n=%0d exp 5 ending 43,52", ar_q.size());
        else n_pass++;
        for (int i = 0; i < pd.size(); i++)
            if (pd[i] != 16 + i || pl[i] != (i == 39)) errs++;
        n_checks++;
        if (pd.size() != 40 || errs != 0)
            $display("FAIL credit_data got n=%0d errs=%0d exp n=40 errs=0", pd.size(), errs);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        clear_mon(); w_ready = 1'b1;
        send_cmd(32'd500, 16'd0);
        #2;
        n_checks++; if (done !== 1'b1) $display("FAIL zero_done_pulse got %b exp 1", done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL zero_cmd_ready got %b exp 1", cmd_ready); else n_pass++;
        @(negedge clk); #2;
        n_checks++; if (done !== 1'b0) $display("FAIL zero_done_single got %b exp 0", done); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++; if (ar_q.size() != 0 || pd.size() != 0)
            $display("FAIL zero_no_traffic got ars=%0d pops=%0d exp 0,0", ar_q.size(), pd.size()); else n_pass++;
    endtask

    task automatic test_short();
        bit ok; int errs = 0;
        clear_mon(); w_ready = 1'b1;
        send_cmd(32'd100, 16'd3);
        wait_done(1, ok);
        n_checks++; if (!ok) $display("FAIL short_done_timeout got %0d dones exp 1", done_c.size()); else n_pass++;
        n_checks++; if (ar_q.size() != 1 || ar_q[0] != 100)
            $display("FAIL short_ar got n=%0d exp one AR at 100", ar_q.size()); else n_pass++;
        repeat (12) @(negedge clk);
        #2;
        for (int i = 0; i < pd.size(); i++)
            if (pd[i] != 100 + i || pl[i] != (i == 2)) errs++;
        n_checks++; if (pd.size() != 3 || errs != 0)
            $display("FAIL short_data got n=%0d errs=%0d exp n=3 errs=0", pd.size(), errs); else n_pass++;
        n_checks++; if (w_valid !== 1'b0) $display("FAIL short_trim got w_valid=%b exp 0", w_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok; int errs = 0;
        clear_mon(); w_ready = 1'b1;
        send_cmd(32'd16, 16'd20);
        for (int i = 0; i < 100; i++) begin
            if (pd.size() >= 4) break;
            @(negedge clk);
        end
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; #2;
        n_checks++;
        if (cmd_ready !== 1'b1 || arvalid !== 1'b0 || araddr !== '0 || w_valid !== 1'b0 ||
            w_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL mid_reset_outputs got rdy=%b arv=%b ara=%0d wv=%b wl=%b busy=%b done=%b exp 1,0,0,0,0,0,0",
                     cmd_ready, arvalid, araddr, w_valid, w_last, busy, done);
        else n_pass++;
        repeat (3) @(negedge clk);
        clear_mon();
        send_cmd(32'd0, 16'd4);
        wait_done(1, ok);
        n_checks++; if (!ok) $display("FAIL mid_reset_done_timeout got %0d dones exp 1", done_c.size()); else n_pass++;
        for (int i = 0; i < pd.size(); i++)
            if (pd[i] != i || pl[i] != (i == 3)) errs++;
        n_checks++; if (pd.size() != 4 || errs != 0 || ar_q.size() != 1 || ar_q[0] != 0)
            $display("FAIL mid_reset_data got n=%0d errs=%0d ars=%0d exp 4,0,1", pd.size(), errs, ar_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok; int errs = 0;
        int unsigned exp_d[7] = '{200, 201, 202, 203, 204, 300, 301};
        clear_mon(); w_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 32'd200; cmd_len = 16'd5;
        for (int i = 0; i < 300 && acc_c.size() < 2; i++) begin
            @(negedge clk);
            if (acc_c.size() == 1) begin cmd_addr = 32'd300; cmd_len = 16'd2; end
        end
        cmd_valid = 1'b0;
        wait_done(2, ok);
        n_checks++; if (!ok) $display("FAIL b2b_done_timeout got %0d dones exp 2", done_c.size()); else n_pass++;
        n_checks++; if (acc_c.size() != 2 || done_c.size() == 0 || acc_c[1] != done_c[0])
            $display("FAIL b2b_accept_cycle got %0d exp %0d", acc_c.size() > 1 ? acc_c[1] : -1,
                     done_c.size() ? done_c[0] : -1);
        else n_pass++;
        for (int i = 0; i < pd.size() && i < 7; i++)
            if (pd[i] != exp_d[i] || pl[i] != (i == 4 || i == 6)) errs++;
        n_checks++; if (pd.size() != 7 || errs != 0)
            $display("FAIL b2b_data got n=%0d errs=%0d exp n=7 errs=0", pd.size(), errs); else n_pass++;
        n_checks++; if (ar_q.size() != 2 || ar_q[0] != 200 || ar_q[1] != 300)
            $display("FAIL b2b_ar got n=%0d exp 200,300", ar_q.size()); else n_pass++;
        n_checks++; if (ar_viol != 0) $display("FAIL arvalid_without_arready got %0d exp 0", ar_viol); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_credit();
        test_zero_len();
        test_short();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
